// File: rtl/life_pkg.sv
// Shared definitions for the SD pattern loader.
// Contents:
//   load_state_t        loader FSM state encoding
//   RDR_INIT/READ/FINISH encodings of the block reader state bus
//   BLOCK_BYTES          bytes per SD block
//   GRID_ADDR_W          width of the grid byte address
//   BYTE_IDX_W           width of a byte index inside one block
package life_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ISSUE    = 3'd1,
    ST_WAIT_ACK = 3'd2,
    ST_WAIT_FIN = 3'd3,
    ST_RD_ADDR  = 3'd4,
    ST_WRITE    = 3'd5,
    ST_NEXT     = 3'd6,
    ST_DONE     = 3'd7
  } load_state_t;

  localparam logic [1:0] RDR_INIT   = 2'd0;
  localparam logic [1:0] RDR_READ   = 2'd1;
  localparam logic [1:0] RDR_FINISH = 2'd2;

  localparam int BLOCK_BYTES = 512;
  localparam int GRID_ADDR_W = 12;
  localparam int BYTE_IDX_W  = 9;

endpackage

// File: rtl/sd_pattern_loader_if.sv
// Bus bundle between the pattern loader, the SD block reader and the grid
// write port.
//   blk_id/blk_execute   block read request towards the reader
//   blk_state            reader progress (INIT/READ/FINISH)
//   blk_rd_addr/data     byte access into the reader buffer
//   grid_we/waddr/wdata  grid write request, completed by grid_wready
// master: the loader. slave: the reader plus grid memory side.
interface sd_pattern_loader_if;
  import life_pkg::*;

  logic [31:0]            blk_id;
  logic                   blk_execute;
  logic [1:0]             blk_state;
  logic [8:0]             blk_rd_addr;
  logic [7:0]             blk_rd_data;
  logic                   grid_we;
  logic [GRID_ADDR_W-1:0] grid_waddr;
  logic [7:0]             grid_wdata;
  logic                   grid_wready;

  modport master (
    output blk_id, blk_execute, blk_rd_addr, grid_we, grid_waddr, grid_wdata,
    input  blk_state, blk_rd_data, grid_wready
  );

  modport slave (
    input  blk_id, blk_execute, blk_rd_addr, grid_we, grid_waddr, grid_wdata,
    output blk_state, blk_rd_data, grid_wready
  );

endinterface

// File: rtl/sd_pattern_loader.sv
// Loads one pattern file (BLOCKS_PER_FILE consecutive SD blocks) into the
// grid memory, one byte per two cycles.
// Ports:
//   clk_spi, reset_n  clock and asynchronous active-low reset
//   load_req, file_id start a load of the selected file (accepted in idle only)
//   abort             level, cancels an active load
//   busy, done, err   status: load running, completion pulse, sticky timeout
//   bus               master side of sd_pattern_loader_if (reader + grid)
// All outputs are flops loaded from next-state values, so they line up
// exactly with the state they belong to.
module sd_pattern_loader
  import life_pkg::*;
#(
  parameter int unsigned BLOCKS_PER_FILE = 8,
  parameter int unsigned FILE_BASE_BLOCK = 0,
  parameter int unsigned TIMEOUT_CYC     = 5_000_000
) (
  input  logic                clk_spi,
  input  logic                reset_n,
  input  logic                load_req,
  input  logic                abort,
  input  logic [3:0]          file_id,
  output logic                busy,
  output logic                done,
  output logic                err,
  sd_pattern_loader_if.master bus
);

  // Block index bits that fit in the grid address above the byte index.
  localparam int K_W = GRID_ADDR_W - BYTE_IDX_W;
  localparam logic [31:0]           TMO_LAST = 32'(TIMEOUT_CYC - 1);
  localparam logic [31:0]           K_LAST   = 32'(BLOCKS_PER_FILE - 1);
  localparam logic [BYTE_IDX_W-1:0] N_LAST   = BYTE_IDX_W'(BLOCK_BYTES - 1);

  load_state_t           state_r, state_nx;
  logic [3:0]            fid_r, fid_nx;
  logic [31:0]           k_r, k_nx;
  logic [BYTE_IDX_W-1:0] n_r, n_nx;
  logic [31:0]           tmo_r, tmo_nx;
  logic                  err_r, err_nx;
  logic [7:0]            wdata_r, wdata_nx;
  logic [31:0]           blk_id_s;

  logic                   busy_r, done_r, exec_r, we_r;
  logic [31:0]            blk_id_r;
  logic [BYTE_IDX_W-1:0]  rd_addr_r;
  logic [GRID_ADDR_W-1:0] waddr_r;

  // Block id of the block about to be issued; wraps modulo 2^32.
  always_comb begin
    blk_id_s = 32'(FILE_BASE_BLOCK) + (32'(BLOCKS_PER_FILE) * {28'd0, fid_nx}) + k_nx;
  end

  // Next-state and datapath update logic.
  always_comb begin
    state_nx = state_r;
    fid_nx   = fid_r;
    k_nx     = k_r;
    n_nx     = n_r;
    tmo_nx   = tmo_r;
    err_nx   = err_r;
    wdata_nx = wdata_r;
    case (state_r)
      ST_IDLE: begin
        if (load_req && !abort) begin
          state_nx = ST_ISSUE;
          fid_nx   = file_id;
          k_nx     = 32'd0;
          err_nx   = 1'b0;
        end else begin
          state_nx = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        tmo_nx   = 32'd0;
        state_nx = ST_WAIT_ACK;
      end
      ST_WAIT_ACK, ST_WAIT_FIN: begin
        // The timeout wins over a same-cycle reader transition.
        if (tmo_r == TMO_LAST) begin
          err_nx   = 1'b1;
          state_nx = ST_IDLE;
        end else begin
          tmo_nx = tmo_r + 32'd1;
          if (state_r == ST_WAIT_ACK) begin
            if (bus.blk_state != RDR_FINISH) begin
              state_nx = ST_WAIT_FIN;
            end else begin
              state_nx = ST_WAIT_ACK;
            end
          end else if (bus.blk_state == RDR_FINISH) begin
            n_nx     = '0;
            state_nx = ST_RD_ADDR;
          end else begin
            state_nx = ST_WAIT_FIN;
          end
        end
      end
      ST_RD_ADDR: begin
        // The reader has had the whole cycle to settle on blk_rd_addr.
        wdata_nx = bus.blk_rd_data;
        state_nx = ST_WRITE;
      end
      ST_WRITE: begin
        if (bus.grid_wready) begin
          if (n_r == N_LAST) begin
            state_nx = ST_NEXT;
          end else begin
            n_nx     = n_r + 9'd1;
            state_nx = ST_RD_ADDR;
          end
        end else begin
          state_nx = ST_WRITE;
        end
      end
      ST_NEXT: begin
        if (k_r == K_LAST) begin
          state_nx = ST_DONE;
        end else begin
          k_nx     = k_r + 32'd1;
          state_nx = ST_ISSUE;
        end
      end
      ST_DONE: begin
        state_nx = ST_IDLE;
      end
      default: begin
        state_nx = ST_IDLE;
      end
    endcase
    // Abort overrides everything except a write already granted this cycle,
    // which has completed on the grid side regardless; err is left alone.
    if (abort && (state_r != ST_IDLE)) begin
      state_nx = ST_IDLE;
      err_nx   = err_r;
    end else begin
      state_nx = state_nx;
    end
  end

  // State, datapath and output registers.
  always_ff @(posedge clk_spi or negedge reset_n) begin
    if (!reset_n) begin
      state_r   <= ST_IDLE;
      fid_r     <= 4'd0;
      k_r       <= 32'd0;
      n_r       <= '0;
      tmo_r     <= 32'd0;
      err_r     <= 1'b0;
      wdata_r   <= 8'd0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      exec_r    <= 1'b0;
      we_r      <= 1'b0;
      blk_id_r  <= 32'd0;
      rd_addr_r <= '0;
      waddr_r   <= '0;
    end else begin
      state_r <= state_nx;
      fid_r   <= fid_nx;
      k_r     <= k_nx;
      n_r     <= n_nx;
      tmo_r   <= tmo_nx;
      err_r   <= err_nx;
      wdata_r <= wdata_nx;
      busy_r  <= (state_nx != ST_IDLE) && (state_nx != ST_DONE);
      done_r  <= (state_nx == ST_DONE);
      exec_r  <= (state_nx == ST_ISSUE);
      we_r    <= (state_nx == ST_WRITE);
      if (state_nx == ST_ISSUE) begin
        blk_id_r <= blk_id_s;
      end
      if (state_nx == ST_RD_ADDR) begin
        rd_addr_r <= n_nx;
      end
      if (state_nx == ST_WRITE) begin
        waddr_r <= {k_nx[K_W-1:0], n_nx};
      end
    end
  end

  assign busy            = busy_r;
  assign done            = done_r;
  assign err             = err_r;
  assign bus.blk_id      = blk_id_r;
  assign bus.blk_execute = exec_r;
  assign bus.blk_rd_addr = rd_addr_r;
  assign bus.grid_we     = we_r;
  assign bus.grid_waddr  = waddr_r;
  assign bus.grid_wdata  = wdata_r;

endmodule

// File: tb/tb_sd_pattern_loader.sv
// Directed bench for sd_pattern_loader: reader model, grid write monitor,
// full load with a grid stall, abort/restart, timeout and mid-load reset.
module tb_sd_pattern_loader;
  import life_pkg::*;

  logic       clk_spi = 1'b0;
  logic       reset_n = 1'b0;
  logic       load_req = 1'b0;
  logic       abort = 1'b0;
  logic [3:0] file_id = 4'd0;
  logic       busy, done, err;

  sd_pattern_loader_if bus();

  sd_pattern_loader #(
    .BLOCKS_PER_FILE(8),
    .FILE_BASE_BLOCK(0),
    .TIMEOUT_CYC(100)
  ) dut (
    .clk_spi (clk_spi),
    .reset_n (reset_n),
    .load_req(load_req),
    .abort   (abort),
    .file_id (file_id),
    .busy    (busy),
    .done    (done),
    .err     (err),
    .bus     (bus)
  );

  always #5 clk_spi = ~clk_spi;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Content of byte a of SD block b as seen in the reader buffer.
  function automatic logic [7:0] pat(input logic [31:0] b, input logic [8:0] a);
    logic [7:0] hi;
    hi = a[8] ? 8'hA5 : 8'h00;
    return (b[7:0] * 8'd29) ^ a[7:0] ^ hi;
  endfunction

  // Block reader model: FINISH 20 cycles after execute unless hung.
  logic [31:0] rdr_blk;
  int          rdr_cnt;
  logic        rdr_hang = 1'b0;
  always @(posedge clk_spi or negedge reset_n) begin
    if (!reset_n) begin
      bus.blk_state <= RDR_INIT;
      rdr_cnt       <= 0;
      rdr_blk       <= 32'd0;
    end else if (bus.blk_execute) begin
      rdr_blk       <= bus.blk_id;
      rdr_cnt       <= 20;
      bus.blk_state <= RDR_READ;
    end else if ((bus.blk_state == RDR_READ) && !rdr_hang) begin
      if (rdr_cnt == 1) bus.blk_state <= RDR_FINISH;
      rdr_cnt <= rdr_cnt - 1;
    end
  end
  assign bus.blk_rd_data = pat(rdr_blk, bus.blk_rd_addr);

  // Monitor: grid writes, stall stability, done pulses and executed block ids.
  int          wr_idx = 0;
  int          done_cnt = 0;
  logic [31:0] exec_q[$];
  logic        hold_v = 1'b0;
  logic [11:0] hold_addr;
  logic [7:0]  hold_data;
  int          wr_base = 0;
  logic [31:0] exp_base = 32'd0;
  always @(negedge clk_spi) begin
    int idx;
    if (hold_v) begin
      check_eq("hold_we", 32'(bus.grid_we), 32'd1);
      check_eq("hold_waddr", 32'(bus.grid_waddr), 32'(hold_addr));
      check_eq("hold_wdata", 32'(bus.grid_wdata), 32'(hold_data));
    end
    if (bus.grid_we && !bus.grid_wready) begin
      hold_v    = 1'b1;
      hold_addr = bus.grid_waddr;
      hold_data = bus.grid_wdata;
    end else begin
      hold_v = 1'b0;
    end
    if (bus.grid_we && bus.grid_wready) begin
      idx = wr_idx - wr_base;
      check_eq("waddr", 32'(bus.grid_waddr), 32'(idx[11:0]));
      check_eq("wdata", 32'(bus.grid_wdata), 32'(pat(exp_base + 32'(idx >> 9), idx[8:0])));
      wr_idx++;
    end
    if (done) done_cnt++;
    if (bus.blk_execute) exec_q.push_back(bus.blk_id);
  end

  int exec_base = 0;
  int done_base = 0;

  task automatic tick(input int n);
    repeat (n) @(posedge clk_spi);
    #1;
  endtask

  task automatic start_load(input logic [3:0] fid);
    exp_base  = 32'(fid) * 32'd8;
    wr_base   = wr_idx;
    exec_base = exec_q.size();
    done_base = done_cnt;
    file_id   = fid;
    load_req  = 1'b1;
    tick(1);
    load_req  = 1'b0;
  endtask

  task automatic wait_wr(input int n, input int bound);
    int t = 0;
    while (((wr_idx - wr_base) < n) && (t < bound)) begin
      tick(1);
      t++;
    end
    check_eq("wr_reached", 32'(wr_idx - wr_base), 32'(n));
  endtask

  task automatic wait_done(input int bound);
    int t = 0;
    while ((done_cnt == done_base) && (t < bound)) begin
      tick(1);
      t++;
    end
    check_eq("done_seen", 32'(done_cnt - done_base), 32'd1);
  endtask

  task automatic check_zero_outputs(input string tag);
    check_eq({tag, "_busy"}, 32'(busy), 32'd0);
    check_eq({tag, "_done"}, 32'(done), 32'd0);
    check_eq({tag, "_err"}, 32'(err), 32'd0);
    check_eq({tag, "_exec"}, 32'(bus.blk_execute), 32'd0);
    check_eq({tag, "_we"}, 32'(bus.grid_we), 32'd0);
    check_eq({tag, "_blk_id"}, bus.blk_id, 32'd0);
    check_eq({tag, "_rd_addr"}, 32'(bus.blk_rd_addr), 32'd0);
    check_eq({tag, "_waddr"}, 32'(bus.grid_waddr), 32'd0);
    check_eq({tag, "_wdata"}, 32'(bus.grid_wdata), 32'd0);
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int t;
    int exec_snap;
    logic [31:0] got_id;
    bus.grid_wready = 1'b1;

    // Reset state.
    tick(3);
    check_zero_outputs("reset");
    reset_n = 1'b1;
    tick(2);

    // Full load of file 3, grid stall mid block 1, ignored load_req while busy.
    start_load(4'd3);
    check_eq("busy_after_req", 32'(busy), 32'd1);
    fork
      wait_done(12000);
      begin
        wait_wr(612, 6000);
        bus.grid_wready = 1'b0;
        tick(10);
        bus.grid_wready = 1'b1;
        file_id  = 4'd5;
        load_req = 1'b1;
        tick(1);
        load_req = 1'b0;
      end
    join
    tick(3);
    check_eq("a_done_count", 32'(done_cnt - done_base), 32'd1);
    check_eq("a_writes", 32'(wr_idx - wr_base), 32'd4096);
    check_eq("a_exec_count", 32'(exec_q.size() - exec_base), 32'd8);
    for (int i = 0; i < 8; i++) begin
      got_id = ((exec_base + i) < exec_q.size()) ? exec_q[exec_base + i] : 32'hFFFF_FFFF;
      check_eq("a_blk_id_seq", got_id, 32'(24 + i));
    end
    check_eq("a_busy_end", 32'(busy), 32'd0);
    check_eq("a_err_end", 32'(err), 32'd0);

    // Abort at byte 200 of block 2, then restart from the file base.
    start_load(4'd2);
    wait_wr(1224, 4000);
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    check_eq("b_abort_busy", 32'(busy), 32'd0);
    check_eq("b_abort_we", 32'(bus.grid_we), 32'd0);
    check_eq("b_abort_err", 32'(err), 32'd0);
    tick(4);
    check_eq("b_abort_writes", 32'(wr_idx - wr_base), 32'd1224);
    check_eq("b_abort_no_done", 32'(done_cnt - done_base), 32'd0);
    start_load(4'd2);
    wait_wr(5, 200);
    got_id = (exec_base < exec_q.size()) ? exec_q[exec_base] : 32'hFFFF_FFFF;
    check_eq("b_restart_blk_id", got_id, 32'd16);
    abort = 1'b1;
    tick(1);
    abort = 1'b0;

    // Reader never finishes: timeout sets err and drops busy.
    rdr_hang = 1'b1;
    start_load(4'd1);
    check_eq("c_exec_pulse", 32'(bus.blk_execute), 32'd1);
    t = 0;
    while (busy && (t < 200)) begin
      tick(1);
      t++;
    end
    check_eq("c_tmo_window", 32'((t >= 100) && (t <= 102)), 32'd1);
    check_eq("c_err_set", 32'(err), 32'd1);
    tick(5);
    check_eq("c_err_sticky", 32'(err), 32'd1);
    check_eq("c_no_done", 32'(done_cnt - done_base), 32'd0);
    rdr_hang = 1'b0;
    start_load(4'd1);
    check_eq("c_err_cleared", 32'(err), 32'd0);
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    tick(2);

    // Reset pulsed during WAIT_FIN of file 5 (blk_id 40).
    start_load(4'd5);
    tick(6);
    check_eq("d_blk_id_before", bus.blk_id, 32'd40);
    #2;
    reset_n = 1'b0;
    #1;
    check_zero_outputs("d_async");
    exec_snap = exec_q.size();
    done_base = done_cnt;
    tick(2);
    reset_n = 1'b1;
    tick(30);
    check_eq("d_idle_busy", 32'(busy), 32'd0);
    check_eq("d_no_reexec", 32'(exec_q.size() - exec_snap), 32'd0);
    check_eq("d_no_done", 32'(done_cnt - done_base), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
